// File: rtl/fetch_stage_if.sv
// Bundle of the fetch-stage bus: imem address/data, hazard-unit controls
// and the IF/ID register outputs.
// Optional macro: FETCH_PERF_CNT_EN adds the two performance counters.
// master = the fetch stage itself; slave = its surroundings (imem, hazard
// unit and the decode stage).
interface fetch_stage_if;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fault_d;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  modport master (
    output imem_a,
    output instr_d,
    output pc_d,
    output pc_plus4_d,
    output valid_d,
    output fault_d,
    output halted,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetch_cnt,
    output perf_stall_cnt,
`endif
    input  imem_rd,
    input  stall_f,
    input  stall_d,
    input  flush_d,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_a,
    input  instr_d,
    input  pc_d,
    input  pc_plus4_d,
    input  valid_d,
    input  fault_d,
    input  halted,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetch_cnt,
    input  perf_stall_cnt,
`endif
    output imem_rd,
    output stall_f,
    output stall_d,
    output flush_d,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, drives the combinational imem, fills
// the IF/ID register, obeys stall/flush/redirect and can halt on a fault
// (out-of-bounds sentinel word or misaligned PC).
// Optional macro: FETCH_PERF_CNT_EN adds fetch and stall counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h00400000,
  parameter logic [31:0] NOP_INSTR     = 32'h00000013,
  parameter logic [31:0] OOB_SENTINEL  = 32'hDEADBEEF,
  parameter bit          HALT_ON_FAULT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_stage_if.master  bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // A fetch is bad if imem flagged it out of range or the PC is not word aligned.
  function automatic logic fetch_fault(input logic [31:0] word, input logic [31:0] pc);
    return (word == OOB_SENTINEL) || (pc[1:0] != 2'b00);
  endfunction

  // Sequential PC step; the 32-bit add wraps 0xFFFFFFFC to 0.
  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pc4_id_q, pc4_id_d;
  logic        valid_id_q, valid_id_d;
  logic        fault_id_q, fault_id_d;

  logic        fault_f;
  logic [31:0] pc_plus4_f;
  logic        load_f;

  assign fault_f    = fetch_fault(bus.imem_rd, pc_q);
  assign pc_plus4_f = pc_step(pc_q);
  // IF/ID captures the fetched word only when nothing blocks it.
  assign load_f     = !bus.flush_d && !bus.stall_d && (state_q == ST_RUN);

  assign bus.imem_a     = pc_q;
  assign bus.instr_d    = instr_id_q;
  assign bus.pc_d       = pc_id_q;
  assign bus.pc_plus4_d = pc4_id_q;
  assign bus.valid_d    = valid_id_q;
  assign bus.fault_d    = fault_id_q;
  assign bus.halted     = (state_q == ST_HALT);

  // PCF next value: redirect beats halt, halt beats stall, else step by 4.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (state_q == ST_HALT) begin
      pc_d = pc_q;
    end else if (bus.stall_f) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_plus4_f;
    end
  end

  // IF/ID next value: flush beats stall; a halted fetch feeds bubbles.
  always_comb begin
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    fault_id_d = fault_id_q;
    if (bus.flush_d || (!bus.stall_d && (state_q == ST_HALT))) begin
      instr_id_d = NOP_INSTR;
      pc_id_d    = 32'd0;
      pc4_id_d   = 32'd0;
      valid_id_d = 1'b0;
      fault_id_d = 1'b0;
    end else if (load_f) begin
      instr_id_d = bus.imem_rd;
      pc_id_d    = pc_q;
      pc4_id_d   = pc_plus4_f;
      valid_id_d = 1'b1;
      fault_id_d = fault_f;
    end
  end

  // Fetch FSM: halt once a faulting word is committed to IF/ID, leave on redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (HALT_ON_FAULT && load_f && fault_f) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.redirect_valid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Stage boundary IF -> ID: PC, FSM and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      instr_id_q <= NOP_INSTR;
      pc_id_q    <= 32'd0;
      pc4_id_q   <= 32'd0;
      valid_id_q <= 1'b0;
      fault_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
      fault_id_q <= fault_id_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count real IF/ID loads and front-end stall cycles not cancelled by a redirect.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (load_f) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bus.stall_f && !bus.redirect_valid) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.perf_fetch_cnt = fetch_cnt_q;
  assign bus.perf_stall_cnt = stall_cnt_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process pushes hand-computed
// expectations tagged with a cycle number; a monitor pops and compares them.
// imem model: word(a) = {8'h13, a[23:0]}, except 0x004000A4 returns 0xDEADBEEF.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC      (32'h00400000),
    .NOP_INSTR     (32'h00000013),
    .OOB_SENTINEL  (32'hDEADBEEF),
    .HALT_ON_FAULT (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_rd = (bus.imem_a == 32'h004000A4) ? 32'hDEADBEEF
                                                    : {8'h13, bus.imem_a[23:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] a;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
    logic        f;
    logic        h;
  } exp_t;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] fetch;
    logic [31:0] stall;
  } perf_t;

  exp_t  exp_q[$];
  perf_t perf_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic [31:0] a, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic v, input logic f, input logic h);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.a = a; e.instr = instr; e.pc = pc; e.pc4 = pc4;
    e.v = v; e.f = f; e.h = h;
    exp_q.push_back(e);
  endtask

  task automatic expect_perf(input string nm, input logic [31:0] fc, input logic [31:0] sc);
    perf_t p;
    p.cyc = cyc; p.name = nm; p.fetch = fc; p.stall = sc;
    perf_q.push_back(p);
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fl,
                       input logic rv, input logic [31:0] rpc);
    bus.stall_f = sf; bus.stall_d = sd; bus.flush_d = fl;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
  endtask

  // Monitor: compare every expectation whose cycle has been reached.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.imem_a !== e.a || bus.instr_d !== e.instr || bus.pc_d !== e.pc ||
            bus.pc_plus4_d !== e.pc4 || bus.valid_d !== e.v || bus.fault_d !== e.f ||
            bus.halted !== e.h) begin
          errors++;
          $display("FAIL %s: got a=%h i=%h pc=%h pc4=%h v=%b f=%b h=%b, want a=%h i=%h pc=%h pc4=%h v=%b f=%b h=%b",
                   e.name, bus.imem_a, bus.instr_d, bus.pc_d, bus.pc_plus4_d, bus.valid_d,
                   bus.fault_d, bus.halted, e.a, e.instr, e.pc, e.pc4, e.v, e.f, e.h);
        end
      end
`ifdef FETCH_PERF_CNT_EN
      while (perf_q.size() > 0 && perf_q[0].cyc <= cyc) begin
        perf_t p;
        p = perf_q.pop_front();
        checks++;
        if (bus.perf_fetch_cnt !== p.fetch || bus.perf_stall_cnt !== p.stall) begin
          errors++;
          $display("FAIL %s: got fetch=%0d stall=%0d, want fetch=%0d stall=%0d",
                   p.name, bus.perf_fetch_cnt, bus.perf_stall_cnt, p.fetch, p.stall);
        end
      end
`else
      perf_q.delete();
`endif
    end
  end

  // Stimulus: directed sequence with hand-computed expectations.
  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    expect_st("reset", 32'h00400000, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_perf("perf_reset", 32'd0, 32'd0);
    rst_n = 1'b1;

    // Free run from the reset PC.
    tick(); expect_st("run1", 32'h00400004, 32'h13400000, 32'h00400000, 32'h00400004, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("run2", 32'h00400008, 32'h13400004, 32'h00400004, 32'h00400008, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("run3", 32'h0040000C, 32'h13400008, 32'h00400008, 32'h0040000C, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("run4", 32'h00400010, 32'h1340000C, 32'h0040000C, 32'h00400010, 1'b1, 1'b0, 1'b0);

    // Stall both F and D for three cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_st("stall", 32'h00400010, 32'h1340000C, 32'h0040000C, 32'h00400010, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("resume1", 32'h00400014, 32'h13400010, 32'h00400010, 32'h00400014, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("resume2", 32'h00400018, 32'h13400014, 32'h00400014, 32'h00400018, 1'b1, 1'b0, 1'b0);

    // Redirect overriding stall_f, with flush.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h00400040);
    tick(); expect_st("redir_flush", 32'h00400040, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("redir_load", 32'h00400044, 32'h13400040, 32'h00400040, 32'h00400044, 1'b1, 1'b0, 1'b0);
    expect_perf("perf_mid", 32'd7, 32'd3);

    // Out-of-bounds sentinel at 0x004000A4 halts fetch.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h004000A0);
    tick(); expect_st("to_a0", 32'h004000A0, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("load_a0", 32'h004000A4, 32'h134000A0, 32'h004000A0, 32'h004000A4, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("oob_fault", 32'h004000A8, 32'hDEADBEEF, 32'h004000A4, 32'h004000A8, 1'b1, 1'b1, 1'b1);
    tick(); expect_st("halt_bub1", 32'h004000A8, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(); expect_st("halt_bub2", 32'h004000A8, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400000);
    tick(); expect_st("halt_exit", 32'h00400000, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("after_halt", 32'h00400004, 32'h13400000, 32'h00400000, 32'h00400004, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect faults on the following fetch.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h00400002);
    tick(); expect_st("to_mis", 32'h00400002, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("mis_fault", 32'h00400006, 32'h13400002, 32'h00400002, 32'h00400006, 1'b1, 1'b1, 1'b1);
    tick(); expect_st("mis_halt", 32'h00400006, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // PC wrap at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
    tick(); expect_st("to_top", 32'hFFFFFFFC, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("wrap", 32'h00000000, 32'h13FFFFFC, 32'hFFFFFFFC, 32'h00000000, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("post_wrap", 32'h00000004, 32'h13000000, 32'h00000000, 32'h00000004, 1'b1, 1'b0, 1'b0);

    // flush_d together with stall_d: flush wins; PC still advances.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(); expect_st("flush_vs_stall", 32'h00000008, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); expect_st("pre_reset", 32'h0000000C, 32'h13000008, 32'h00000008, 32'h0000000C, 1'b1, 1'b0, 1'b0);
    expect_perf("perf_pre_reset", 32'd14, 32'd3);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_st("async_rst", 32'h00400000, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    expect_perf("perf_async_rst", 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); expect_st("post_reset", 32'h00400004, 32'h13400000, 32'h00400000, 32'h00400004, 1'b1, 1'b0, 1'b0);

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && (exp_q.size() > 0 || perf_q.size() > 0); i++) begin
      @(negedge clk);
      #2;
    end
    if (exp_q.size() > 0 || perf_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size() + perf_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RISC-V pipeline CPU, sitting directly upstream of the combinational instruction memory.
- Owns the program counter (PCF) and drives it as the imem address.
- Captures the returned word into the IF/ID pipeline register.
- Honours hazard-unit stall, flush and redirect controls.
- Detects out-of-bounds fetches (sentinel 0xDEADBEEF) and misaligned PCs, and can halt fetch on them.

Parameters:
RESET_PC, 32'h00400000, PCF value after reset (text segment base)
NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) loaded into instr_d on reset/flush
OOB_SENTINEL, 32'hDEADBEEF, imem word that marks an out-of-bounds fetch
HALT_ON_FAULT, 1, 1 = enter HALT after a fault is latched into D; 0 = flag only

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_a  out  32  fetch address to imem (= PCF, combinational)
imem_rd  in  32  instruction word from imem (combinational, same cycle)
stall_f  in  1  hold PCF
stall_d  in  1  hold IF/ID register
flush_d  in  1  bubble IF/ID register
redirect_valid  in  1  taken branch/jump resolved in EX
redirect_pc  in  32  target address for redirect
instr_d  out  32  IF/ID instruction
pc_d  out  32  IF/ID PC
pc_plus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction
fault_d  out  1  IF/ID instruction came from a faulting fetch
halted  out  1  fetch FSM is in HALT

Behaviour:
- One clock domain. rst_n is asynchronous assert, synchronous-release use.
- Reset values: PCF=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fault_d=0, halted=0, FSM=RUN.
- imem_a = PCF combinationally. Latency: an instruction at PCF appears on instr_d one clock later.
- fault_f (combinational) = (imem_rd==OOB_SENTINEL) | (PCF[1:0]!=0).
- PCF update, priority order:
  1. redirect_valid: PCF<=redirect_pc. Overrides stall_f and HALT.
  2. FSM==HALT: hold.
  3. stall_f: hold.
  4. Otherwise PCF<=PCF+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- redirect_pc is not realigned; a misaligned target faults on the following fetch.
- IF/ID update, priority order:
  1. flush_d: valid_d<=0, instr_d<=NOP_INSTR, fault_d<=0. pc_d and pc_plus4_d also load 0.
  2. stall_d: hold all fields.
  3. FSM==HALT: load bubble, same as flush.
  4. Otherwise instr_d<=imem_rd, pc_d<=PCF, pc_plus4_d<=PCF+4, valid_d<=1, fault_d<=fault_f.
- flush_d and stall_d asserted together: flush wins.
- A redirect does not by itself flush IF/ID; the hazard unit asserts flush_d alongside it.
- FSM states RUN and HALT:
  - RUN->HALT when HALT_ON_FAULT=1 and the IF/ID load in this cycle captures fault_f=1 with valid (rule 4 taken).
  - HALT->RUN on redirect_valid, or on reset.
  - In HALT: halted=1, PCF frozen, D fed bubbles. The faulting instruction already in D stays one cycle with fault_d=1, unless stall_d holds it longer.
  - HALT_ON_FAULT=0: FSM never leaves RUN; fault_d is flag-only.
- Reset mid-operation: all state returns to reset values immediately, with no dependence on clk.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on every IF/ID load with valid_d<=1.
  - perf_stall_cnt increments on every cycle with stall_f=1 and no redirect.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run 4 cycles with imem returning PC-based words: imem_a 0x00400000,04,08,0C. instr_d/pc_d lag one cycle; valid_d rises on cycle 1; pc_plus4_d=pc_d+4.
- stall_f=stall_d=1 for 3 cycles at PCF=0x00400010: imem_a, instr_d and pc_d all constant. Resume: next pc_d=0x00400010, then 0x00400014.
- redirect_valid=1, redirect_pc=0x00400040, with flush_d=1 and stall_f=1 same cycle: next imem_a=0x00400040, valid_d=0, instr_d=0x00000013. Following cycle pc_d=0x00400040.
- imem_rd=0xDEADBEEF at PCF=0x004000A4 with HALT_ON_FAULT=1: next cycle fault_d=1 and halted=1. PCF stays 0x004000A8 and bubbles follow. redirect to 0x00400000 clears halted and fetch resumes.
- Misaligned redirect_pc=0x00400002: next D entry fault_d=1. PC wrap: force PCF=0xFFFFFFFC via redirect, next imem_a=0x00000000.
- rst_n low mid-stream, asynchronous and between clock edges: outputs reach reset values before the next edge. With FETCH_PERF_CNT_EN, 5 fetches and 2 stall cycles give perf_fetch_cnt=5 and perf_stall_cnt=2.
